// File: rtl/ddp_fp_pkg.sv
// ddp_fp_pkg: shared defaults and helpers for the FP-stage pipeline blocks.
package ddp_fp_pkg;
    localparam int PKT_W     = 32;
    localparam int CNT_W_DEF = 16;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return (v == max) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/ce_elim_ring.sv
// ce_elim_ring: DEPTH-entry circular packet store with wrapping rd/wr pointers and occupancy count.
module ce_elim_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Gate to zero when empty so reset and drained states show no stale data.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ce_elim_buffer.sv
// ce_elim_buffer: Send/Ack pipeline buffer that deletes packets on entry when elimination is enabled,
// with a per-transfer CE_CP pulse and saturating pass/delete counters.
module ce_elim_buffer
    import ddp_fp_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic             Send_in,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Exb_in,
    output logic             Ack_out,
    output logic             Send_out,
    output logic [WIDTH-1:0] Data_out,
    input  logic             Ack_in,
    input  logic             Elim_en,
    input  logic             Cnt_clr,
    output logic             CE_CP,
    output logic [CNT_W-1:0] Pass_cnt,
    output logic [CNT_W-1:0] Del_cnt
);
    logic del, acc, push, pop, full, empty;

    assign del      = Elim_en & ~Exb_in;
    // Deleted packets are absorbed even when full; kept ones never bypass a full store.
    assign Ack_out  = ~full | del;
    assign acc      = Send_in & Ack_out;
    assign push     = acc & ~del;
    assign pop      = Send_out & Ack_in;
    assign Send_out = ~empty;

    ce_elim_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ring (
        .clk     (CLK),
        .rst_n   (MR_n),
        .push    (push),
        .pop     (pop),
        .wr_data (Data_in),
        .rd_data (Data_out),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            CE_CP    <= 1'b0;
            Pass_cnt <= '0;
            Del_cnt  <= '0;
        end else begin
            CE_CP    <= acc;
            Pass_cnt <= Cnt_clr ? '0 : push ? CNT_W'(sat_inc(32'(Pass_cnt), CNT_W)) : Pass_cnt;
            Del_cnt  <= Cnt_clr ? '0 : (acc & del) ? CNT_W'(sat_inc(32'(Del_cnt), CNT_W)) : Del_cnt;
        end
    end
endmodule

// File: tb/tb_ce_elim_buffer.sv
// tb_ce_elim_buffer: scoreboard bench for ce_elim_buffer (DEPTH=2, CNT_W=4).
module tb_ce_elim_buffer;
    logic        CLK = 0, MR_n = 1, Send_in = 0, Exb_in = 0, Ack_in = 0, Elim_en = 0, Cnt_clr = 0;
    logic [31:0] Data_in = 0;
    logic        Ack_out, Send_out, CE_CP;
    logic [31:0] Data_out;
    logic [3:0]  Pass_cnt, Del_cnt;

    int checks = 0, passed = 0, ce_cnt = 0, out_cnt = 0;
    logic [31:0] exp_q[$];

    ce_elim_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut (
        .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in), .Exb_in(Exb_in),
        .Ack_out(Ack_out), .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
        .Elim_en(Elim_en), .Cnt_clr(Cnt_clr), .CE_CP(CE_CP), .Pass_cnt(Pass_cnt), .Del_cnt(Del_cnt)
    );

    always #5 CLK = ~CLK;

    // Output monitor: samples 2 time units after the falling edge, ahead of the next rising edge.
    always begin
        @(negedge CLK);
        #2;
        if (MR_n) begin
            if (CE_CP) ce_cnt++;
            if (Send_out && Ack_in) begin
                checks++;
                out_cnt++;
                if (exp_q.size() == 0)
                    $display("FAIL out_unexpected: got %h, expected no output", Data_out);
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (Data_out !== e) $display("FAIL out_data: got %h, expected %h", Data_out, e);
                    else passed++;
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] d, input logic exb, input int tries, output logic ok);
        Send_in = 1; Data_in = d; Exb_in = exb; ok = 0;
        for (int n = 0; n < tries && !ok; n++) begin
            #1;
            if (Ack_out) begin
                ok = 1;
                if (!(Elim_en && !exb)) exp_q.push_back(d);
            end
            @(negedge CLK);
        end
        Send_in = 0;
    endtask

    task automatic must_send(input logic [31:0] d, input logic exb);
        logic ok;
        send(d, exb, 20, ok);
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: packet %h not acknowledged within 20 cycles", d);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic clear_stats;
        Cnt_clr = 1;
        @(negedge CLK);
        Cnt_clr = 0;
        @(negedge CLK);
        ce_cnt = 0; out_cnt = 0;
    endtask

    task automatic drain;
        Ack_in = 1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_reset;
        #2 MR_n = 0;
        #1;
        check("reset_send_out", 32'(Send_out), 0);
        check("reset_data_out", Data_out, 0);
        check("reset_ack_out", 32'(Ack_out), 1);
        check("reset_ce_cp", 32'(CE_CP), 0);
        check("reset_cnts", {Pass_cnt, Del_cnt}, 0);
        @(negedge CLK);
        MR_n = 1;
        @(negedge CLK);
    endtask

    task automatic test_pass;
        Elim_en = 0; Ack_in = 1;
        clear_stats();
        must_send(32'hA5A5_0001, 1);
        #1;
        check("pass_latency_send_out", 32'(Send_out), 1);
        check("pass_latency_data", Data_out, 32'hA5A5_0001);
        must_send(32'hA5A5_0002, 0);
        must_send(32'hA5A5_0003, 1);
        must_send(32'hA5A5_0004, 0);
        drain();
        check("pass_out_cnt", out_cnt, 4);
        check("pass_pass_cnt", 32'(Pass_cnt), 4);
        check("pass_del_cnt", 32'(Del_cnt), 0);
    endtask

    task automatic test_delete;
        Elim_en = 1; Ack_in = 1;
        clear_stats();
        must_send(32'h11, 1);
        must_send(32'h22, 0);
        must_send(32'h33, 1);
        drain();
        check("del_out_cnt", out_cnt, 2);
        check("del_pass_cnt", 32'(Pass_cnt), 2);
        check("del_del_cnt", 32'(Del_cnt), 1);
        check("del_ce_cp_pulses", ce_cnt, 3);
    endtask

    task automatic test_full;
        logic ok;
        Elim_en = 1; Ack_in = 0;
        clear_stats();
        must_send(32'h100, 1);
        must_send(32'h200, 1);
        send(32'h300, 1, 1, ok);
        check("full_kept_not_acked", 32'(ok), 0);
        check("full_ack_out", 32'(Ack_out), 0);
        check("full_data_held", Data_out, 32'h100);
        must_send(32'h400, 0);
        check("full_del_cnt", 32'(Del_cnt), 1);
        Ack_in = 1;
        send(32'h500, 1, 1, ok);
        check("full_no_passthrough", 32'(ok), 0);
        drain();
        check("full_out_cnt", out_cnt, 2);
        check("full_pass_cnt", 32'(Pass_cnt), 2);
    endtask

    task automatic test_back_to_back;
        Elim_en = 0; Ack_in = 0;
        clear_stats();
        must_send(32'hB000, 1);
        Ack_in = 1;
        for (int i = 1; i <= 10; i++) begin
            must_send(32'hB000 + 32'(i), 1);
            #1;
            check("b2b_send_out", 32'(Send_out), 1);
            check("b2b_not_full", 32'(Ack_out), 1);
            @(negedge CLK);
            Ack_in = 1;
        end
        drain();
        check("b2b_out_cnt", out_cnt, 11);
        check("b2b_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_saturation;
        Elim_en = 1; Ack_in = 1;
        clear_stats();
        for (int i = 0; i < 20; i++) must_send(32'(i), 0);
        check("sat_del_cnt", 32'(Del_cnt), 15);
        check("sat_pass_cnt", 32'(Pass_cnt), 0);
        Cnt_clr = 1;
        must_send(32'hDEAD, 0);
        Cnt_clr = 0;
        check("clr_priority_del_cnt", 32'(Del_cnt), 0);
    endtask

    task automatic test_reset_mid;
        Elim_en = 0; Ack_in = 0;
        clear_stats();
        must_send(32'hC001, 1);
        must_send(32'hC002, 1);
        check("mid_full_before_reset", 32'(Ack_out), 0);
        #1 MR_n = 0;
        #1;
        check("mid_reset_send_out", 32'(Send_out), 0);
        check("mid_reset_ack_out", 32'(Ack_out), 1);
        check("mid_reset_cnts", {Pass_cnt, Del_cnt}, 0);
        check("mid_reset_data_out", Data_out, 0);
        exp_q.delete();
        @(negedge CLK);
        MR_n = 1;
        Ack_in = 1;
        repeat (3) @(negedge CLK);
        check("mid_no_partial_output", out_cnt, 0);
    endtask

    initial begin
        test_reset();
        test_pass();
        test_delete();
        test_full();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
